ether_rx_parser: RTL and testbench

- Receive-side framer in the Ethernet path, consuming the MAC RX byte stream.
- Strips and checks the 14-byte header (destination, source, EtherType) and writes payload bytes to the RX data FIFO.
- At frame end, pushes one frame-info word to the RX frame-info FIFO.
- For accepted good frames, pulses frameInfoLoad with the header fields. The downstream Ethernet transmitter latches them to address its reply.

---
 rtl/ether_rx_parser_if.sv | 31 +++
 rtl/ether_rx_parser.sv | 160 ++++++++++++++++
 tb/tb_ether_rx_parser.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ether_rx_parser_if.sv
// Byte-stream and FIFO-write bundle between the MAC RX path, the parser and
// the two RX FIFOs. The parser holds the master view.
interface ether_rx_parser_if;
    // Handshake semantics: the MAC side has no back-pressure. A byte on RXdata
    // is consumed on every cycle RXdataValid is high, and RXgoodFrame /
    // RXbadFrame are single-cycle end-of-frame pulses. The FIFO side is
    // strobe-only: rxFifoIn/rfFifoIn are written on each cycle their write
    // enable is high. The parser never writes a data byte in a cycle where
    // rxFifoFull was seen high. rfFifoFull is checked once, at header accept,
    // which reserves room for that frame's info word.
    logic [7:0]  RXdata;
    logic        RXdataValid;
    logic        RXgoodFrame;
    logic        RXbadFrame;
    logic [7:0]  rxFifoIn;
    logic        rxWrEn;
    logic        rxFifoFull;
    logic [11:0] rfFifoIn;
    logic        rfWrEn;
    logic        rfFifoFull;

    modport master (
        input  RXdata, RXdataValid, RXgoodFrame, RXbadFrame, rxFifoFull, rfFifoFull,
        output rxFifoIn, rxWrEn, rfFifoIn, rfWrEn
    );

    modport slave (
        output RXdata, RXdataValid, RXgoodFrame, RXbadFrame, rxFifoFull, rfFifoFull,
        input  rxFifoIn, rxWrEn, rfFifoIn, rfWrEn
    );
endinterface

// File: rtl/ether_rx_parser.sv
// Ethernet RX framer. It strips the 14-byte header (dst, src, EtherType),
// forwards payload bytes to the RX data FIFO, and pushes one {drop, len}
// info word per accepted frame. Header fields of good frames are published
// with a frameInfoLoad pulse so the transmitter can address its reply.
module ether_rx_parser #(
    parameter logic [15:0] ETHER_TYPE = 16'h88B5,
    parameter logic [10:0] MAX_LEN    = 11'd1500
) (
    input  logic              ethRXclock,
    input  logic              reset,
    input  logic [47:0]       myMacAddr,
    ether_rx_parser_if.master bus,
    output logic              frameInfoLoad,
    output logic [47:0]       srcMacAddr,
    output logic [47:0]       dstMacAddr,
    output logic [15:0]       etherType,
    output logic [15:0]       frameCount,
    output logic [15:0]       dropCount,
    output logic [2:0]        parse_state
);
    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_DST  = 3'd1,
        R_SRC  = 3'd2,
        R_TYPE = 3'd3,
        R_DATA = 3'd4,
        R_DROP = 3'd5,
        R_DONE = 3'd6
    } state_t;

    state_t      state;
    logic        valid_d;    // resets high so a frame running at reset release is skipped
    logic [3:0]  hdr_idx;    // index of the next header byte, 0..13
    logic [47:0] dst_sh;
    logic [47:0] src_sh;
    logic [15:0] type_sh;
    logic [10:0] len;
    logic        ovf;
    logic        bad;
    logic        from_data;  // frame ended from R_DATA, so an info word is owed
    logic        rise;
    logic        status;
    logic        accept;
    logic        drop;
    logic [15:0] type_full;

    assign parse_state = state;

    // Frame start, end-of-frame status and header verdict from the live inputs
    always_comb begin
        rise      = bus.RXdataValid & ~valid_d;
        status    = bus.RXgoodFrame | bus.RXbadFrame;
        type_full = {type_sh[7:0], bus.RXdata};
        accept    = ((dst_sh == myMacAddr) || (dst_sh == 48'hFFFF_FFFF_FFFF))
                    && (type_full == ETHER_TYPE) && !bus.rfFifoFull;
        drop      = bad | ovf | (len == 11'd0);
    end

    // Parser FSM with all outputs registered
    always_ff @(posedge ethRXclock or posedge reset) begin
        if (reset) begin
            state         <= R_IDLE;
            valid_d       <= 1'b1;
            hdr_idx       <= '0;
            dst_sh        <= '0;
            src_sh        <= '0;
            type_sh       <= '0;
            len           <= '0;
            ovf           <= 1'b0;
            bad           <= 1'b0;
            from_data     <= 1'b0;
            bus.rxFifoIn  <= '0;
            bus.rxWrEn    <= 1'b0;
            bus.rfFifoIn  <= '0;
            bus.rfWrEn    <= 1'b0;
            frameInfoLoad <= 1'b0;
            srcMacAddr    <= '0;
            dstMacAddr    <= '0;
            etherType     <= '0;
            frameCount    <= '0;
            dropCount     <= '0;
        end else begin
            valid_d       <= bus.RXdataValid;
            bus.rxWrEn    <= 1'b0;
            bus.rfWrEn    <= 1'b0;
            frameInfoLoad <= 1'b0;
            case (state)
                R_IDLE, R_DONE: begin
                    if (state == R_DONE) begin
                        if (from_data) begin
                            bus.rfWrEn   <= 1'b1;
                            bus.rfFifoIn <= {drop, len};
                            if (!drop) begin
                                frameInfoLoad <= 1'b1;
                                srcMacAddr    <= src_sh;
                                dstMacAddr    <= dst_sh;
                                etherType     <= type_sh;
                                if (frameCount != 16'hFFFF) frameCount <= frameCount + 16'd1;
                            end else if (dropCount != 16'hFFFF) begin
                                dropCount <= dropCount + 16'd1;
                            end
                        end else if (dropCount != 16'hFFFF) begin
                            dropCount <= dropCount + 16'd1;
                        end
                    end
                    // A new frame may start in R_DONE; its first byte is dst[47:40]
                    if (rise) begin
                        dst_sh  <= {dst_sh[39:0], bus.RXdata};
                        hdr_idx <= 4'd1;
                        len     <= '0;
                        ovf     <= 1'b0;
                        bad     <= 1'b0;
                        state   <= R_DST;
                    end else begin
                        state <= R_IDLE;
                    end
                end
                R_DST, R_SRC, R_TYPE: begin
                    if (status) begin
                        // Runt: handled exactly like a dropped frame
                        from_data <= 1'b0;
                        state     <= R_DONE;
                    end else if (bus.RXdataValid) begin
                        hdr_idx <= hdr_idx + 4'd1;
                        if (state == R_DST)      dst_sh  <= {dst_sh[39:0], bus.RXdata};
                        else if (state == R_SRC) src_sh  <= {src_sh[39:0], bus.RXdata};
                        else                     type_sh <= type_full;
                        if (hdr_idx == 4'd5)       state <= R_SRC;
                        else if (hdr_idx == 4'd11) state <= R_TYPE;
                        else if (hdr_idx == 4'd13) state <= accept ? R_DATA : R_DROP;
                    end
                end
                R_DATA: begin
                    if (bus.RXdataValid && !ovf) begin
                        if ((len < MAX_LEN) && !bus.rxFifoFull) begin
                            bus.rxWrEn   <= 1'b1;
                            bus.rxFifoIn <= bus.RXdata;
                            len          <= len + 11'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    if (status) begin
                        // Simultaneous good and bad counts as bad
                        bad       <= bus.RXbadFrame;
                        from_data <= 1'b1;
                        state     <= R_DONE;
                    end
                end
                R_DROP: begin
                    if (status) begin
                        from_data <= 1'b0;
                        state     <= R_DONE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ether_rx_parser.sv
// Bench for ether_rx_parser: directed scenarios plus randomized frames,
// checked against a frame-level reference model.
module tb_ether_rx_parser;
    localparam logic [47:0] MY_MAC = 48'h0010_A47B_EA80;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE  = 16'h88B5;
    localparam int          MAXL   = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] my_mac;
    logic        frame_info_load;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
    logic [15:0] ether_type;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic [2:0]  parse_state;

    ether_rx_parser_if bus ();

    ether_rx_parser dut (
        .ethRXclock    (clk),
        .reset         (rst),
        .myMacAddr     (my_mac),
        .bus           (bus),
        .frameInfoLoad (frame_info_load),
        .srcMacAddr    (src_mac),
        .dstMacAddr    (dst_mac),
        .etherType     (ether_type),
        .frameCount    (frame_count),
        .dropCount     (drop_count),
        .parse_state   (parse_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [11:0] exp_info_q[$];
    logic [7:0]  got_data[$];
    logic [11:0] got_info[$];
    int          rd_data = 0;
    int          rd_info = 0;
    int          seen_loads = 0;
    int          addr_glitches = 0;
    int          exp_loads = 0;
    int          exp_frames = 0;
    int          exp_drops = 0;
    logic [47:0] exp_src = '0;
    logic [47:0] exp_dst = '0;
    logic [15:0] exp_type = '0;
    logic [7:0]  frame[$];
    logic [47:0] prev_src = '0;
    logic [47:0] prev_dst = '0;
    logic [15:0] prev_type = '0;

    // Monitor: capture FIFO writes and header loads away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rxWrEn) got_data.push_back(bus.rxFifoIn);
            if (bus.rfWrEn) got_info.push_back(bus.rfFifoIn);
            if (frame_info_load) seen_loads++;
            else if (src_mac != prev_src || dst_mac != prev_dst || ether_type != prev_type)
                addr_glitches++;
        end
        prev_src  = src_mac;
        prev_dst  = dst_mac;
        prev_type = ether_type;
    end

    // Watchdog: every wait is a fixed cycle count, this only guards a hang
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] typ, input int plen, input bit ramp);
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(src[47 - 8*i -: 8]);
        frame.push_back(typ[15:8]);
        frame.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++)
            frame.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // Reference model: whole-frame view. sts 0=good 1=bad 2=both.
    // full_at = payload index from which rxFifoFull is high (-1: never).
    task automatic model_frame(input int sts, input int full_at, input bit rf_full);
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        int          plen;
        int          lim;
        bit          drop;
        if (frame.size() < 14) begin
            if (exp_drops < 65535) exp_drops++;
            return;
        end
        d = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        s = {frame[6], frame[7], frame[8], frame[9], frame[10], frame[11]};
        t = {frame[12], frame[13]};
        if (!((d == my_mac || d == BCAST) && t == ETYPE && !rf_full)) begin
            if (exp_drops < 65535) exp_drops++;
            return;
        end
        plen = frame.size() - 14;
        lim  = plen;
        if (lim > MAXL) lim = MAXL;
        if (full_at >= 0 && lim > full_at) lim = full_at;
        for (int i = 0; i < lim; i++) exp_q.push_back(frame[14 + i]);
        drop = (sts != 0) || (plen > lim) || (lim == 0);
        exp_info_q.push_back({drop, 11'(lim)});
        if (drop) begin
            if (exp_drops < 65535) exp_drops++;
        end else begin
            if (exp_frames < 65535) exp_frames++;
            exp_loads++;
            exp_src  = s;
            exp_dst  = d;
            exp_type = t;
        end
    endtask

    // Driver: one byte per cycle, status pulse after the last byte, then idle
    task automatic send_frame(input int sts, input int full_at, input bit rf_full, input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            @(posedge clk); #1;
            bus.RXdataValid = 1'b1;
            bus.RXdata      = frame[i];
            bus.rxFifoFull  = (full_at >= 0) && (i - 14 >= full_at);
            bus.rfFifoFull  = rf_full;
        end
        @(posedge clk); #1;
        bus.RXdataValid = 1'b0;
        bus.RXdata      = '0;
        bus.rxFifoFull  = 1'b0;
        bus.RXgoodFrame = (sts != 1);
        bus.RXbadFrame  = (sts != 0);
        @(posedge clk); #1;
        bus.RXgoodFrame = 1'b0;
        bus.RXbadFrame  = 1'b0;
        bus.rfFifoFull  = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rxWrEn, bus.rfWrEn, frame_info_load, parse_state} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b required=000000", {bus.rxWrEn, bus.rfWrEn, frame_info_load, parse_state});
        end
        checks++;
        if ({src_mac, dst_mac, ether_type, bus.rxFifoIn, bus.rfFifoIn} !== '0) begin
            failures++;
            $display("FAIL reset_fields got=%h/%h/%h/%h/%h required=0", src_mac, dst_mac, ether_type, bus.rxFifoIn, bus.rfFifoIn);
        end
        checks++;
        if ({frame_count, drop_count} !== 32'h0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d required=0/0", frame_count, drop_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_unicast();
        int nd;
        int bad_n;
        build_frame(MY_MAC, 48'h0A0B_0C0D_0E0F, ETYPE, 64, 1'b1);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != 64 || bad_n != 0) begin
            failures++;
            $display("FAIL unicast_data got=%0d bytes/%0d wrong required=64 bytes/0 wrong", nd, bad_n);
        end
        rd_data = got_data.size(); exp_q.delete();
        checks++;
        if (got_info.size() - rd_info != 1 || got_info[rd_info] !== 12'h040) begin
            failures++;
            $display("FAIL unicast_info got=%0d words required=1 word 040", got_info.size() - rd_info);
        end
        rd_info = got_info.size(); exp_info_q.delete();
        checks++;
        if ({src_mac, dst_mac, ether_type} !== {48'h0A0B_0C0D_0E0F, MY_MAC, ETYPE}) begin
            failures++;
            $display("FAIL unicast_hdr got=%h/%h/%h required=0a0b0c0d0e0f/%h/88b5", src_mac, dst_mac, ether_type, MY_MAC);
        end
        checks++;
        if (frame_count !== 16'd1 || seen_loads != 1) begin
            failures++;
            $display("FAIL unicast_count got=frames %0d loads %0d required=1/1", frame_count, seen_loads);
        end
    endtask

    task automatic test_wrong_type();
        build_frame(BCAST, 48'h0222_3344_5566, 16'h0800, 20, 1'b0);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        settle();
        checks++;
        if (got_data.size() != rd_data || got_info.size() != rd_info) begin
            failures++;
            $display("FAIL wrongtype_writes got=%0d data %0d info required=0/0", got_data.size() - rd_data, got_info.size() - rd_info);
        end
        rd_data = got_data.size(); rd_info = got_info.size();
        checks++;
        if (drop_count !== 16'd1 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL wrongtype_count got=drops %0d frames %0d required=1/1", drop_count, frame_count);
        end
        checks++;
        if ({src_mac, dst_mac, ether_type} !== {exp_src, exp_dst, exp_type} || addr_glitches != 0) begin
            failures++;
            $display("FAIL wrongtype_hdr got=%h/%h/%h glitches %0d required=%h/%h/%h/0", src_mac, dst_mac, ether_type, addr_glitches, exp_src, exp_dst, exp_type);
        end
    endtask

    task automatic test_bad_frame();
        int nd;
        int bad_n;
        build_frame(MY_MAC, 48'h0233_4455_6677, ETYPE, 10, 1'b0);
        model_frame(1, -1, 1'b0);
        send_frame(1, -1, 1'b0, 2);
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != 10 || bad_n != 0) begin
            failures++;
            $display("FAIL bad_data got=%0d bytes/%0d wrong required=10 bytes/0 wrong", nd, bad_n);
        end
        rd_data = got_data.size(); exp_q.delete();
        checks++;
        if (got_info.size() - rd_info != 1 || got_info[rd_info] !== 12'h80A) begin
            failures++;
            $display("FAIL bad_info got=%0d words required=1 word 80a", got_info.size() - rd_info);
        end
        rd_info = got_info.size(); exp_info_q.delete();
        checks++;
        if (drop_count !== 16'd2 || seen_loads != exp_loads) begin
            failures++;
            $display("FAIL bad_count got=drops %0d loads %0d required=2/%0d", drop_count, seen_loads, exp_loads);
        end
    endtask

    task automatic test_overflow();
        int nd;
        int bad_n;
        build_frame(MY_MAC, 48'h0244_5566_7788, ETYPE, 1600, 1'b0);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 3);
        build_frame(BCAST, 48'h0255_6677_8899, ETYPE, 12, 1'b0);
        model_frame(0, 5, 1'b0);
        send_frame(0, 5, 1'b0, 3);
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != 1505 || bad_n != 0) begin
            failures++;
            $display("FAIL ovf_data got=%0d bytes/%0d wrong required=1505 bytes/0 wrong", nd, bad_n);
        end
        rd_data = got_data.size(); exp_q.delete();
        checks++;
        if (got_info.size() - rd_info != 2 || got_info[rd_info] !== 12'hDDC || got_info[rd_info + 1] !== 12'h805) begin
            failures++;
            $display("FAIL ovf_info got=%0d words required=2 words ddc,805", got_info.size() - rd_info);
        end
        rd_info = got_info.size(); exp_info_q.delete();
        checks++;
        if (drop_count !== 16'(exp_drops) || frame_count !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL ovf_count got=drops %0d frames %0d required=%0d/%0d", drop_count, frame_count, exp_drops, exp_frames);
        end
    endtask

    task automatic test_runt_and_rffull();
        build_frame(MY_MAC, 48'h0266_7788_99AA, ETYPE, 0, 1'b0);
        while (frame.size() > 8) void'(frame.pop_back());
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        build_frame(MY_MAC, 48'h0277_8899_AABB, ETYPE, 20, 1'b0);
        model_frame(0, -1, 1'b1);
        send_frame(0, -1, 1'b1, 2);
        settle();
        checks++;
        if (got_data.size() != rd_data || got_info.size() != rd_info) begin
            failures++;
            $display("FAIL runt_writes got=%0d data %0d info required=0/0", got_data.size() - rd_data, got_info.size() - rd_info);
        end
        rd_data = got_data.size(); rd_info = got_info.size();
        checks++;
        if (drop_count !== 16'(exp_drops) || frame_count !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL runt_count got=drops %0d frames %0d required=%0d/%0d", drop_count, frame_count, exp_drops, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nd;
        int bad_n;
        build_frame(MY_MAC, 48'h0288_99AA_BBCC, ETYPE, 40, 1'b0);
        for (int i = 0; i < 10; i++) exp_q.push_back(frame[14 + i]);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            bus.RXdataValid = 1'b1;
            bus.RXdata      = frame[i];
        end
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        for (int i = 24; i < 40; i++) begin
            @(posedge clk); #1;
            bus.RXdata = frame[i];
            if (i == 27) rst = 1'b0;
        end
        @(posedge clk); #1;
        bus.RXdataValid = 1'b0;
        bus.RXgoodFrame = 1'b1;
        @(posedge clk); #1;
        bus.RXgoodFrame = 1'b0;
        exp_frames = 0; exp_drops = 0;
        exp_src = '0; exp_dst = '0; exp_type = '0;
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != 10 || bad_n != 0 || got_info.size() != rd_info) begin
            failures++;
            $display("FAIL midreset_writes got=%0d bytes/%0d wrong/%0d info required=10/0/0", nd, bad_n, got_info.size() - rd_info);
        end
        rd_data = got_data.size(); rd_info = got_info.size(); exp_q.delete();
        checks++;
        if ({frame_count, drop_count, src_mac, dst_mac, ether_type} !== '0) begin
            failures++;
            $display("FAIL midreset_state got=frames %0d drops %0d hdr %h required=0/0/0", frame_count, drop_count, src_mac);
        end
        build_frame(MY_MAC, 48'h0299_AABB_CCDD, ETYPE, 16, 1'b0);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        settle();
        checks++;
        if (got_info.size() - rd_info != 1 || got_info[rd_info] !== 12'h010 || frame_count !== 16'd1
            || got_data.size() - rd_data != 16) begin
            failures++;
            $display("FAIL midreset_next got=%0d info %0d bytes frames %0d required=1/16/1", got_info.size() - rd_info, got_data.size() - rd_data, frame_count);
        end
        rd_data = got_data.size(); rd_info = got_info.size(); exp_q.delete(); exp_info_q.delete();
    endtask

    task automatic test_back_to_back();
        int nd;
        int bad_n;
        int ni;
        build_frame(MY_MAC, 48'h02AA_0000_0001, ETYPE, 30, 1'b0);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        build_frame(BCAST, 48'h02AA_0000_0002, ETYPE, 25, 1'b0);
        model_frame(0, -1, 1'b0);
        send_frame(0, -1, 1'b0, 2);
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != exp_q.size() || bad_n != 0) begin
            failures++;
            $display("FAIL b2b_data got=%0d bytes/%0d wrong required=%0d bytes", nd, bad_n, exp_q.size());
        end
        rd_data = got_data.size(); exp_q.delete();
        ni = got_info.size() - rd_info;
        checks++;
        if (ni != 2 || got_info[rd_info] !== 12'h01E || got_info[rd_info + 1] !== 12'h019) begin
            failures++;
            $display("FAIL b2b_info got=%0d words required=2 words 01e,019", ni);
        end
        rd_info = got_info.size(); exp_info_q.delete();
        checks++;
        if (frame_count !== 16'd3 || seen_loads != exp_loads
            || {src_mac, dst_mac} !== {48'h02AA_0000_0002, BCAST}) begin
            failures++;
            $display("FAIL b2b_count got=frames %0d loads %0d src %h required=3/%0d/02aa00000002", frame_count, seen_loads, src_mac, exp_loads);
        end
    endtask

    task automatic test_random();
        int nd;
        int bad_n;
        int ni;
        int plen;
        int sts;
        int full_at;
        bit rf_full;
        logic [47:0] dst;
        logic [15:0] typ;
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    dst = MY_MAC;
                2:       dst = BCAST;
                default: dst = {16'h0200, 32'($urandom)};
            endcase
            typ     = ($urandom_range(0, 4) == 0) ? 16'h0800 : ETYPE;
            plen    = $urandom_range(0, 60);
            sts     = $urandom_range(0, 5);
            sts     = (sts < 4) ? 0 : sts - 3;
            full_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, plen) : -1;
            rf_full = ($urandom_range(0, 7) == 0);
            build_frame(dst, {16'h02BB, 32'($urandom)}, typ, plen, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                ni = $urandom_range(1, 13);
                while (frame.size() > ni) void'(frame.pop_back());
            end
            model_frame(sts, full_at, rf_full);
            send_frame(sts, full_at, rf_full, $urandom_range(2, 4));
        end
        settle();
        nd = got_data.size() - rd_data; bad_n = 0;
        for (int i = 0; i < nd && i < exp_q.size(); i++) if (got_data[rd_data + i] !== exp_q[i]) bad_n++;
        checks++;
        if (nd != exp_q.size() || bad_n != 0) begin
            failures++;
            $display("FAIL rand_data got=%0d bytes/%0d wrong required=%0d bytes", nd, bad_n, exp_q.size());
        end
        rd_data = got_data.size(); exp_q.delete();
        ni = got_info.size() - rd_info; bad_n = 0;
        for (int i = 0; i < ni && i < exp_info_q.size(); i++) if (got_info[rd_info + i] !== exp_info_q[i]) bad_n++;
        checks++;
        if (ni != exp_info_q.size() || bad_n != 0) begin
            failures++;
            $display("FAIL rand_info got=%0d words/%0d wrong required=%0d words", ni, bad_n, exp_info_q.size());
        end
        rd_info = got_info.size(); exp_info_q.delete();
        checks++;
        if (frame_count !== 16'(exp_frames) || drop_count !== 16'(exp_drops) || seen_loads != exp_loads) begin
            failures++;
            $display("FAIL rand_count got=frames %0d drops %0d loads %0d required=%0d/%0d/%0d", frame_count, drop_count, seen_loads, exp_frames, exp_drops, exp_loads);
        end
        checks++;
        if ({src_mac, dst_mac, ether_type} !== {exp_src, exp_dst, exp_type} || addr_glitches != 0) begin
            failures++;
            $display("FAIL rand_hdr got=%h/%h/%h glitches %0d required=%h/%h/%h/0", src_mac, dst_mac, ether_type, addr_glitches, exp_src, exp_dst, exp_type);
        end
    endtask

    initial begin
        my_mac          = MY_MAC;
        bus.RXdata      = '0;
        bus.RXdataValid = 1'b0;
        bus.RXgoodFrame = 1'b0;
        bus.RXbadFrame  = 1'b0;
        bus.rxFifoFull  = 1'b0;
        bus.rfFifoFull  = 1'b0;
        test_reset();
        test_unicast();
        test_wrong_type();
        test_bad_frame();
        test_overflow();
        test_runt_and_rffull();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
